// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, state encoding and opcodes for fetch_unit
package fetch_unit_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    S_ISSUE = 3'd0,
    S_FWAIT = 3'd1,
    S_EXEC  = 3'd2,
    S_DWR   = 3'd3,
    S_DRD   = 3'd4,
    S_DACK  = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_STR  = 3'b100;
  localparam logic [2:0] OP_LDR  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  function automatic logic is_halt(input logic [2:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// rtl/fetch_unit_pc_counter.sv - program counter with reset load and wrapping increment
//   clk, reset : clock, synchronous active-high reset (loads RESET_PC)
//   en         : advance pc by one, modulo 2^ADDR_W
//   pc         : current program counter
module pc_counter #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (en) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC/IR owner and single-port RAM arbiter between fetch and LDR/STR
//   clk, reset                  : clock, synchronous active-high reset
//   mem_addr/mem_write/mem_wdata: RAM request; mem_rdata returns RAM_LATENCY cycles later
//   instruction, instr_valid    : latched instruction and its valid flag
//   instr_done                  : controller finished the current instruction (level)
//   data_req/data_we/data_addr/data_wdata : data access request, held until data_ack
//   data_ack                    : one-cycle completion pulse
//   mdata                       : last load result
//   pc, halted                  : next fetch address, sticky HALT flag
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                DATA_W      = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  input  logic              instr_done,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] mdata,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam int LAT_W = $clog2(RAM_LATENCY + 1) + 1;

  // The fetch address is already on the bus during S_ISSUE, so S_FWAIT only
  // needs RAM_LATENCY cycles. A load has no separate issue cycle: its first
  // S_DRD cycle presents the address, so S_DRD spans RAM_LATENCY + 1 cycles.
  localparam logic [LAT_W-1:0] FETCH_LAST = LAT_W'(RAM_LATENCY - 1);
  localparam logic [LAT_W-1:0] LOAD_LAST  = LAT_W'(RAM_LATENCY);

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic             fetch_last;
  logic             pc_en;

  assign fetch_last = (state == S_FWAIT) && (lat_cnt == FETCH_LAST);
  assign pc_en      = fetch_last;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .pc    (pc)
  );

  // Outputs are registered: each transition loads the values the next
  // state presents, so mem_addr/mem_write are glitch-free toward the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_ISSUE;
      lat_cnt     <= '0;
      mem_addr    <= RESET_PC;
      mem_write   <= 1'b0;
      mem_wdata   <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      data_ack    <= 1'b0;
      mdata       <= '0;
      halted      <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      data_ack  <= 1'b0;

      case (state)
        S_ISSUE: begin
          state   <= S_FWAIT;
          lat_cnt <= '0;
        end

        S_FWAIT: begin
          if (fetch_last) begin
            instruction <= mem_rdata;
            lat_cnt     <= '0;
            mem_addr    <= '0;
            if (is_halt(mem_rdata[DATA_W-1 -: 3])) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state       <= S_EXEC;
              instr_valid <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end

        S_EXEC: begin
          // A pending data access wins; the controller keeps instr_done held.
          if (data_req) begin
            mem_addr <= data_addr;
            lat_cnt  <= '0;
            if (data_we) begin
              state     <= S_DWR;
              mem_write <= 1'b1;
              mem_wdata <= data_wdata;
            end else begin
              state <= S_DRD;
            end
          end else if (instr_done) begin
            state       <= S_ISSUE;
            instr_valid <= 1'b0;
            mem_addr    <= pc;
          end
        end

        S_DWR: begin
          state     <= S_DACK;
          data_ack  <= 1'b1;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end

        S_DRD: begin
          if (lat_cnt == LOAD_LAST) begin
            mdata    <= mem_rdata;
            state    <= S_DACK;
            data_ack <= 1'b1;
            mem_addr <= '0;
            lat_cnt  <= '0;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end

        S_DACK: begin
          state <= S_EXEC;
        end

        S_HALT: begin
          state <= S_HALT;
        end

        default: begin
          state       <= S_ISSUE;
          mem_addr    <= pc;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;

  // DUT 0: RESET_PC = 0
  logic [7:0]  mem_addr0;
  logic        mem_write0;
  logic [15:0] mem_wdata0;
  logic [15:0] mem_rdata0;
  logic [15:0] instruction0;
  logic        instr_valid0;
  logic        instr_done0;
  logic        data_req0;
  logic        data_we0;
  logic [7:0]  data_addr0;
  logic [15:0] data_wdata0;
  logic        data_ack0;
  logic [15:0] mdata0;
  logic [7:0]  pc0;
  logic        halted0;

  // DUT 1: RESET_PC = 8'hFF for the wrap case
  logic [7:0]  mem_addr1;
  logic        mem_write1;
  logic [15:0] mem_wdata1;
  logic [15:0] mem_rdata1;
  logic [15:0] instruction1;
  logic        instr_valid1;
  logic        instr_done1;
  logic        data_ack1;
  logic [15:0] mdata1;
  logic [7:0]  pc1;
  logic        halted1;

  logic [15:0] ram0 [256];
  logic [15:0] ram1 [256];

  int checks = 0;
  int errors = 0;
  int wr_cnt0 = 0;
  int wr_snap;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00), .RAM_LATENCY(1)) u_dut0 (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr0),
    .mem_write   (mem_write0),
    .mem_wdata   (mem_wdata0),
    .mem_rdata   (mem_rdata0),
    .instruction (instruction0),
    .instr_valid (instr_valid0),
    .instr_done  (instr_done0),
    .data_req    (data_req0),
    .data_we     (data_we0),
    .data_addr   (data_addr0),
    .data_wdata  (data_wdata0),
    .data_ack    (data_ack0),
    .mdata       (mdata0),
    .pc          (pc0),
    .halted      (halted0)
  );

  fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'hFF), .RAM_LATENCY(1)) u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr1),
    .mem_write   (mem_write1),
    .mem_wdata   (mem_wdata1),
    .mem_rdata   (mem_rdata1),
    .instruction (instruction1),
    .instr_valid (instr_valid1),
    .instr_done  (instr_done1),
    .data_req    (1'b0),
    .data_we     (1'b0),
    .data_addr   (8'h00),
    .data_wdata  (16'h0000),
    .data_ack    (data_ack1),
    .mdata       (mdata1),
    .pc          (pc1),
    .halted      (halted1)
  );

  // Synchronous single-port RAMs, read latency 1
  always @(posedge clk) begin
    if (mem_write0) ram0[mem_addr0] <= mem_wdata0;
    mem_rdata0 <= ram0[mem_addr0];
    if (mem_write1) ram1[mem_addr1] <= mem_wdata1;
    mem_rdata1 <= ram1[mem_addr1];
  end

  always @(posedge clk) begin
    if (mem_write0) wr_cnt0 <= wr_cnt0 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    instr_done0 = 1'b0;
    data_req0   = 1'b0;
    data_we0    = 1'b0;
    data_addr0  = 8'h00;
    data_wdata0 = 16'h0000;
    instr_done1 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram0[i] = 16'h0000;
      ram1[i] = 16'h0000;
    end
    ram0[8'h00] = 16'hD207;
    ram0[8'h01] = 16'hE000;
    ram0[8'h21] = 16'h1234;
    ram1[8'hFF] = 16'hA123;
    ram1[8'h00] = 16'h6045;

    tick();
    tick();
    check("rst_valid",  instr_valid0, 0);
    check("rst_pc",     pc0, 8'h00);
    check("rst_halted", halted0, 0);
    check("rst_write",  mem_write0, 0);
    check("rst_instr",  instruction0, 16'h0000);
    check("rst_mdata",  mdata0, 16'h0000);
    check("rst_ack",    data_ack0, 0);
    check("rst_addr",   mem_addr0, 8'h00);
    check("rst_pc1",    pc1, 8'hFF);

    reset = 1'b0;
    tick();  // ISSUE -> FWAIT
    check("fwait_valid", instr_valid0, 0);
    check("fwait_addr",  mem_addr0, 8'h00);
    tick();  // FWAIT -> EXEC
    check("fetch_valid", instr_valid0, 1);
    check("fetch_instr", instruction0, 16'hD207);
    check("fetch_pc",    pc0, 8'h01);
    check("wrap_instr0", instruction1, 16'hA123);
    check("wrap_pc0",    pc1, 8'h00);
    check("wrap_valid0", instr_valid1, 1);

    // STR on dut0, next instruction on dut1
    data_req0   = 1'b1;
    data_we0    = 1'b1;
    data_addr0  = 8'h20;
    data_wdata0 = 16'hBEEF;
    instr_done1 = 1'b1;
    tick();
    check("str_write",  mem_write0, 1);
    check("str_addr",   mem_addr0, 8'h20);
    check("str_wdata",  mem_wdata0, 16'hBEEF);
    check("str_ack0",   data_ack0, 0);
    check("str_valid",  instr_valid0, 1);
    check("wrap_issue_valid", instr_valid1, 0);
    check("wrap_issue_addr",  mem_addr1, 8'h00);
    instr_done1 = 1'b0;
    tick();
    check("str_ack1",   data_ack0, 1);
    check("str_write1", mem_write0, 0);
    check("str_ram",    ram0[8'h20], 16'hBEEF);
    data_req0 = 1'b0;
    tick();
    check("str_ack2",   data_ack0, 0);
    check("str_wrcnt",  wr_cnt0, 1);
    check("wrap_instr1", instruction1, 16'h6045);
    check("wrap_pc1",    pc1, 8'h01);

    // LDR from 0x20
    data_req0  = 1'b1;
    data_we0   = 1'b0;
    data_addr0 = 8'h20;
    tick();
    check("ldr_addr",  mem_addr0, 8'h20);
    check("ldr_wr",    mem_write0, 0);
    check("ldr_ack0",  data_ack0, 0);
    tick();
    check("ldr_ack1",  data_ack0, 0);
    tick();
    check("ldr_ack2",  data_ack0, 1);
    check("ldr_mdata", mdata0, 16'hBEEF);
    check("ldr_instr", instruction0, 16'hD207);
    data_req0 = 1'b0;
    tick();
    check("ldr_ack3",  data_ack0, 0);

    // data_req and instr_done together: load runs first
    data_req0   = 1'b1;
    data_we0    = 1'b0;
    data_addr0  = 8'h21;
    instr_done0 = 1'b1;
    tick();
    check("sim_valid", instr_valid0, 1);
    check("sim_addr",  mem_addr0, 8'h21);
    tick();
    tick();
    check("sim_ack",   data_ack0, 1);
    check("sim_mdata", mdata0, 16'h1234);
    data_req0 = 1'b0;
    tick();
    check("sim_exec",  instr_valid0, 1);
    tick();
    check("sim_issue_valid", instr_valid0, 0);
    check("sim_issue_addr",  mem_addr0, 8'h01);
    instr_done0 = 1'b0;
    tick();
    tick();
    check("halt_flag",  halted0, 1);
    check("halt_pc",    pc0, 8'h02);
    check("halt_valid", instr_valid0, 0);
    wr_snap = wr_cnt0;
    repeat (20) tick();
    check("halt_pc20",   pc0, 8'h02);
    check("halt_flag20", halted0, 1);
    check("halt_nowr",   wr_cnt0, wr_snap);

    reset = 1'b1;
    tick();
    check("halt_rst_flag", halted0, 0);
    check("halt_rst_pc",   pc0, 8'h00);
    reset = 1'b0;
    tick();
    tick();
    check("refetch_valid", instr_valid0, 1);

    // reset during S_DWR
    data_req0   = 1'b1;
    data_we0    = 1'b1;
    data_addr0  = 8'h30;
    data_wdata0 = 16'h5555;
    tick();
    check("mid_write", mem_write0, 1);
    reset     = 1'b1;
    data_req0 = 1'b0;
    tick();
    check("mid_write_low", mem_write0, 0);
    check("mid_pc",        pc0, 8'h00);
    check("mid_valid",     instr_valid0, 0);
    check("mid_ack",       data_ack0, 0);
    reset = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
